// File: rtl/gondola_lock_ctrl.sv
// gondola_lock_ctrl: single-chamber canal lock sequencer (queue, arbitrate, align level, gate interlock).
// Latency: request edge -> counter same edge; IDLE -> ALIGN_A next edge; auto align |dL|*STEP_CYCLES + 1 cycles.
// Backpressure: none; request edges beyond QDEPTH are dropped and flagged on sticky req_drop.
//
// Ports:
//   clk, reset                       clock, async active-high reset
//   arr_sw / dept_sw                 arrival / departure request switches (rising edge)
//   toggle_outer_sw/toggle_inner_sw  gate toggle switches (rising edge)
//   inc/dec_water_level, auto_mode   manual level drive, auto/manual select
//   *_led, outer/inner_open          request/toggle indicators, gate state
//   water_level, *_pending, busy     chamber level, queue depths, transit in progress
//   cur_dir, req_drop                direction served (0 arr, 1 dept), sticky overflow flag
module gondola_lock_ctrl #(
  parameter int LEVEL_W     = 4,
  parameter int OUTER_LEVEL = 2,
  parameter int INNER_LEVEL = 12,
  parameter int STEP_CYCLES = 4,
  parameter int QDEPTH      = 7,
  parameter int CNT_W       = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arr_sw,
  input  logic               dept_sw,
  input  logic               toggle_outer_sw,
  input  logic               toggle_inner_sw,
  input  logic               inc_water_level,
  input  logic               dec_water_level,
  input  logic               auto_mode,
  output logic               arr_led,
  output logic               dept_led,
  output logic               toggle_outer_led,
  output logic               toggle_inner_led,
  output logic               outer_open,
  output logic               inner_open,
  output logic [LEVEL_W-1:0] water_level,
  output logic [CNT_W-1:0]   arr_pending,
  output logic [CNT_W-1:0]   dept_pending,
  output logic               busy,
  output logic               cur_dir,
  output logic               req_drop
);

  localparam int SC_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [LEVEL_W-1:0] LV_OUTER = LEVEL_W'(OUTER_LEVEL);
  localparam logic [LEVEL_W-1:0] LV_INNER = LEVEL_W'(INNER_LEVEL);
  localparam logic [LEVEL_W-1:0] LV_MAX   = {LEVEL_W{1'b1}};
  localparam logic [SC_W-1:0]    SC_LAST  = SC_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(QDEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN_A, S_READY_A, S_OPEN_A, S_ALIGN_B, S_READY_B, S_OPEN_B
  } state_t;

  state_t             r_state;
  logic [LEVEL_W-1:0] r_level;
  logic [SC_W-1:0]    r_step_cnt;
  logic [CNT_W-1:0]   r_arr_cnt, r_dept_cnt;
  logic               r_outer_open, r_inner_open;
  logic               r_req_drop, r_cur_dir, r_last_dir, r_auto_prev;
  logic               r_arr_prev, r_dept_prev, r_tog_o_prev, r_tog_i_prev;

  logic w_arr_edge, w_dept_edge, w_tog_o_edge, w_tog_i_edge;
  logic w_in_align, w_side_b, w_side_inner, w_gate_phase;
  logic w_outer_acc, w_inner_acc, w_tog_acc;
  logic [LEVEL_W-1:0] w_target;
  logic w_at_target, w_up, w_dn, w_stepping;
  logic w_done, w_arr_dec, w_dept_dec, w_pick_dir;

  assign w_arr_edge   = arr_sw & ~r_arr_prev;
  assign w_dept_edge  = dept_sw & ~r_dept_prev;
  assign w_tog_o_edge = toggle_outer_sw & ~r_tog_o_prev;
  assign w_tog_i_edge = toggle_inner_sw & ~r_tog_i_prev;

  // Side A is the entry side: outer for arrivals, inner for departures.
  assign w_side_b     = (r_state == S_ALIGN_B) || (r_state == S_READY_B) || (r_state == S_OPEN_B);
  assign w_side_inner = w_side_b ? ~r_cur_dir : r_cur_dir;
  assign w_target     = w_side_inner ? LV_INNER : LV_OUTER;
  assign w_at_target  = (r_level == w_target);
  assign w_in_align   = (r_state == S_ALIGN_A) || (r_state == S_ALIGN_B);
  assign w_gate_phase = (r_state == S_READY_A) || (r_state == S_OPEN_A) ||
                        (r_state == S_READY_B) || (r_state == S_OPEN_B);
  assign w_outer_acc  = w_gate_phase & ~w_side_inner;
  assign w_inner_acc  = w_gate_phase &  w_side_inner;
  assign w_tog_acc    = (w_outer_acc & w_tog_o_edge) | (w_inner_acc & w_tog_i_edge);

  // Direction of the next level step; manual drive saturates at the rails.
  always_comb begin
    w_up = 1'b0;
    w_dn = 1'b0;
    if (auto_mode) begin
      w_up = (r_level < w_target);
      w_dn = (r_level > w_target);
    end else begin
      w_up = inc_water_level & ~dec_water_level & (r_level != LV_MAX);
      w_dn = dec_water_level & ~inc_water_level & (r_level != '0);
    end
  end

  // No stepping on the cycle ALIGN exits, nor on a mode change (which restarts the step counter).
  assign w_stepping = w_in_align & ~w_at_target & (w_up | w_dn) & (auto_mode == r_auto_prev);

  assign w_done     = (r_state == S_OPEN_B) & w_tog_acc;
  assign w_arr_dec  = w_done & ~r_cur_dir;
  assign w_dept_dec = w_done &  r_cur_dir;
  // Both queues waiting: alternate away from the direction served last.
  assign w_pick_dir = ((r_arr_cnt != '0) && (r_dept_cnt != '0)) ? ~r_last_dir : (r_dept_cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arr_prev   <= 1'b0;
      r_dept_prev  <= 1'b0;
      r_tog_o_prev <= 1'b0;
      r_tog_i_prev <= 1'b0;
      r_auto_prev  <= 1'b0;
    end else begin
      r_arr_prev   <= arr_sw;
      r_dept_prev  <= dept_sw;
      r_tog_o_prev <= toggle_outer_sw;
      r_tog_i_prev <= toggle_inner_sw;
      r_auto_prev  <= auto_mode;
    end
  end

  // Pending counters include the request currently in service; a simultaneous
  // edge and completion cancel out, so a full queue does not drop in that case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arr_cnt  <= '0;
      r_dept_cnt <= '0;
      r_req_drop <= 1'b0;
    end else begin
      if (w_arr_edge && !w_arr_dec) begin
        if (r_arr_cnt == CNT_FULL) r_req_drop <= 1'b1;
        else                       r_arr_cnt  <= r_arr_cnt + CNT_W'(1);
      end else if (!w_arr_edge && w_arr_dec) begin
        r_arr_cnt <= r_arr_cnt - CNT_W'(1);
      end
      if (w_dept_edge && !w_dept_dec) begin
        if (r_dept_cnt == CNT_FULL) r_req_drop <= 1'b1;
        else                        r_dept_cnt <= r_dept_cnt + CNT_W'(1);
      end else if (!w_dept_edge && w_dept_dec) begin
        r_dept_cnt <= r_dept_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level    <= LV_OUTER;
      r_step_cnt <= '0;
    end else if (!w_stepping) begin
      r_step_cnt <= '0;
    end else if (r_step_cnt == SC_LAST) begin
      r_step_cnt <= '0;
      r_level    <= w_up ? r_level + LEVEL_W'(1) : r_level - LEVEL_W'(1);
    end else begin
      r_step_cnt <= r_step_cnt + SC_W'(1);
    end
  end

  // Gates only open from READY with the level matched, so the interlock holds by construction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cur_dir    <= 1'b0;
      r_last_dir   <= 1'b1;
      r_outer_open <= 1'b0;
      r_inner_open <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((r_arr_cnt != '0) || (r_dept_cnt != '0)) begin
            r_cur_dir <= w_pick_dir;
            r_state   <= S_ALIGN_A;
          end
        end
        S_ALIGN_A: if (w_at_target) r_state <= S_READY_A;
        S_ALIGN_B: if (w_at_target) r_state <= S_READY_B;
        S_READY_A, S_READY_B: begin
          if (w_tog_acc && w_at_target) begin
            r_outer_open <= ~w_side_inner;
            r_inner_open <=  w_side_inner;
            r_state      <= (r_state == S_READY_A) ? S_OPEN_A : S_OPEN_B;
          end
        end
        S_OPEN_A: begin
          if (w_tog_acc) begin
            r_outer_open <= 1'b0;
            r_inner_open <= 1'b0;
            r_state      <= S_ALIGN_B;
          end
        end
        S_OPEN_B: begin
          if (w_tog_acc) begin
            r_outer_open <= 1'b0;
            r_inner_open <= 1'b0;
            r_last_dir   <= r_cur_dir;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign arr_led          = (r_arr_cnt != '0);
  assign dept_led         = (r_dept_cnt != '0);
  assign toggle_outer_led = w_outer_acc;
  assign toggle_inner_led = w_inner_acc;
  assign outer_open       = r_outer_open;
  assign inner_open       = r_inner_open;
  assign water_level      = r_level;
  assign arr_pending      = r_arr_cnt;
  assign dept_pending     = r_dept_cnt;
  assign busy             = (r_state != S_IDLE);
  assign cur_dir          = r_cur_dir;
  assign req_drop         = r_req_drop;

endmodule

// File: tb/tb_gondola_lock_ctrl.sv
module tb_gondola_lock_ctrl;
  logic       clk = 1'b0;
  logic       reset, arr_sw, dept_sw, toggle_outer_sw, toggle_inner_sw;
  logic       inc_water_level, dec_water_level, auto_mode;
  logic       arr_led, dept_led, toggle_outer_led, toggle_inner_led;
  logic       outer_open, inner_open, busy, cur_dir, req_drop;
  logic [3:0] water_level;
  logic [2:0] arr_pending, dept_pending;

  int n_assert = 0;
  int n_fail   = 0;

  gondola_lock_ctrl dut (
    .clk(clk), .reset(reset), .arr_sw(arr_sw), .dept_sw(dept_sw),
    .toggle_outer_sw(toggle_outer_sw), .toggle_inner_sw(toggle_inner_sw),
    .inc_water_level(inc_water_level), .dec_water_level(dec_water_level),
    .auto_mode(auto_mode), .arr_led(arr_led), .dept_led(dept_led),
    .toggle_outer_led(toggle_outer_led), .toggle_inner_led(toggle_inner_led),
    .outer_open(outer_open), .inner_open(inner_open), .water_level(water_level),
    .arr_pending(arr_pending), .dept_pending(dept_pending), .busy(busy),
    .cur_dir(cur_dir), .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic side, input logic with_arr);
    if (side) toggle_inner_sw = 1'b1; else toggle_outer_sw = 1'b1;
    arr_sw = with_arr;
    tick();
    toggle_inner_sw = 1'b0;
    toggle_outer_sw = 1'b0;
    arr_sw = 1'b0;
  endtask

  task automatic pulse_req(input logic dept);
    if (dept) dept_sw = 1'b1; else arr_sw = 1'b1;
    tick();
    dept_sw = 1'b0;
    arr_sw = 1'b0;
    tick();
  endtask

  task automatic wait_led(input logic side, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((side ? toggle_inner_led : toggle_outer_led) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, {7'd0, ok}, 8'd1);
  endtask

  task automatic wait_busy(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, {7'd0, ok}, 8'd1);
  endtask

  // Full auto transit in direction dir (0 arrival: outer then inner; 1 departure: inner then outer).
  task automatic run_transit(input logic dir, input logic arr_on_close);
    logic [7:0] lv_a, lv_b;
    lv_a = dir ? 8'd12 : 8'd2;
    lv_b = dir ? 8'd2 : 8'd12;
    wait_busy("tr_busy");
    chk("tr_cur_dir", {7'd0, cur_dir}, {7'd0, dir});
    wait_led(dir, "tr_ready_a");
    press(dir, 1'b0);
    chk("tr_open_a", {7'd0, dir ? inner_open : outer_open}, 8'd1);
    chk("tr_lvl_a", {4'd0, water_level}, lv_a);
    tick();
    press(dir, 1'b0);
    chk("tr_close_a", {6'd0, outer_open, inner_open}, 8'd0);
    wait_led(~dir, "tr_ready_b");
    press(~dir, 1'b0);
    chk("tr_open_b", {7'd0, dir ? outer_open : inner_open}, 8'd1);
    chk("tr_lvl_b", {4'd0, water_level}, lv_b);
    tick();
    press(~dir, arr_on_close);
    chk("tr_close_b", {6'd0, outer_open, inner_open}, 8'd0);
    chk("tr_idle", {7'd0, busy}, 8'd0);
  endtask

  initial begin
    reset = 1'b1; arr_sw = 1'b1; dept_sw = 1'b0;
    toggle_outer_sw = 1'b0; toggle_inner_sw = 1'b0;
    inc_water_level = 1'b0; dec_water_level = 1'b0; auto_mode = 1'b1;
    tick(); tick();
    chk("rst_level", {4'd0, water_level}, 8'd2);
    chk("rst_leds", {4'd0, arr_led, dept_led, toggle_outer_led, toggle_inner_led}, 8'd0);
    chk("rst_gates_busy", {5'd0, outer_open, inner_open, busy}, 8'd0);
    chk("rst_cnts", {2'd0, arr_pending, dept_pending}, 8'd0);
    chk("rst_drop_dir", {6'd0, req_drop, cur_dir}, 8'd0);

    // arr_sw held high across reset release counts once.
    reset = 1'b0;
    tick();
    chk("held_edge_cnt", {5'd0, arr_pending}, 8'd1);
    chk("held_edge_led", {7'd0, arr_led}, 8'd1);
    chk("idle_first", {7'd0, busy}, 8'd0);
    tick();
    chk("align_a_busy", {7'd0, busy}, 8'd1);
    chk("align_a_led", {7'd0, toggle_outer_led}, 8'd0);
    tick();
    chk("ready_a_led", {6'd0, toggle_outer_led, toggle_inner_led}, 8'd2);
    chk("held_edge_once", {5'd0, arr_pending}, 8'd1);
    arr_sw = 1'b0;
    press(1'b1, 1'b0);
    chk("inner_tog_ignored", {7'd0, inner_open}, 8'd0);
    press(1'b0, 1'b0);
    chk("outer_open", {7'd0, outer_open}, 8'd1);
    tick();
    press(1'b0, 1'b0);
    chk("outer_closed", {6'd0, outer_open, toggle_outer_led}, 8'd0);
    repeat (39) tick();
    chk("lvl_39cyc", {4'd0, water_level}, 8'd11);
    tick();
    chk("lvl_40cyc", {4'd0, water_level}, 8'd12);
    chk("still_align_b", {7'd0, toggle_inner_led}, 8'd0);
    tick();
    chk("ready_b_led", {7'd0, toggle_inner_led}, 8'd1);
    press(1'b1, 1'b0);
    chk("inner_open", {7'd0, inner_open}, 8'd1);
    tick();
    press(1'b1, 1'b0);
    chk("transit_done", {6'd0, inner_open, busy}, 8'd0);
    chk("arr_cleared", {4'd0, arr_led, arr_pending}, 8'd0);

    // Fairness: level is 12, queue 2 arrivals then 2 departures.
    pulse_req(1'b0); pulse_req(1'b0); pulse_req(1'b1); pulse_req(1'b1);
    chk("fair_q", {2'd0, arr_pending, dept_pending}, {2'd0, 3'd2, 3'd2});
    chk("fair_dept_led", {7'd0, dept_led}, 8'd1);
    run_transit(1'b0, 1'b0);
    chk("fair_q1", {2'd0, arr_pending, dept_pending}, {2'd0, 3'd1, 3'd2});
    run_transit(1'b1, 1'b0);
    chk("fair_q2", {2'd0, arr_pending, dept_pending}, {2'd0, 3'd1, 3'd1});
    run_transit(1'b0, 1'b0);
    run_transit(1'b1, 1'b0);
    chk("fair_q4", {2'd0, arr_pending, dept_pending}, 8'd0);
    chk("fair_lvl", {4'd0, water_level}, 8'd2);

    // Overflow at QDEPTH, then a request coinciding with completion.
    for (int i = 0; i < 7; i++) pulse_req(1'b0);
    chk("ovf_7", {4'd0, req_drop, arr_pending}, 8'd7);
    pulse_req(1'b0);
    chk("ovf_8", {4'd0, req_drop, arr_pending}, 8'd15);
    run_transit(1'b0, 1'b1);
    chk("inc_dec_same", {5'd0, arr_pending}, 8'd7);
    wait_busy("ovf_next_busy");
    wait_led(1'b0, "ovf_next_ready");
    press(1'b0, 1'b0);
    chk("pre_rst_open", {7'd0, outer_open}, 8'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_open", {7'd0, outer_open}, 8'd0);
    chk("rst_mid_state", {5'd0, busy, req_drop, arr_led}, 8'd0);
    chk("rst_mid_cnt", {5'd0, arr_pending}, 8'd0);
    tick();

    // Manual mode.
    auto_mode = 1'b0;
    inc_water_level = 1'b1;
    reset = 1'b0;
    repeat (10) tick();
    chk("man_idle_ignored", {4'd0, water_level}, 8'd2);
    inc_water_level = 1'b0;
    pulse_req(1'b0);
    wait_led(1'b0, "man_ready_a");
    press(1'b0, 1'b0);
    tick();
    press(1'b0, 1'b0);
    repeat (5) tick();
    chk("man_align_b_hold", {3'd0, toggle_inner_led, water_level}, 8'd2);
    press(1'b1, 1'b0);
    chk("man_early_inner", {7'd0, inner_open}, 8'd0);
    tick();
    inc_water_level = 1'b1; dec_water_level = 1'b1;
    repeat (10) tick();
    chk("man_both_frozen", {4'd0, water_level}, 8'd2);
    inc_water_level = 1'b0;
    repeat (4) tick();
    chk("man_dec_1", {4'd0, water_level}, 8'd1);
    repeat (4) tick();
    chk("man_dec_0", {4'd0, water_level}, 8'd0);
    repeat (6) tick();
    chk("man_dec_sat", {4'd0, water_level}, 8'd0);
    inc_water_level = 1'b1;
    tick();
    dec_water_level = 1'b0;
    repeat (20) tick();
    chk("man_inc_5", {3'd0, busy, water_level}, 8'd21);
    reset = 1'b1;
    #1;
    chk("rst_align_b", {3'd0, busy, water_level}, 8'd2);
    inc_water_level = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
